multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multi-cycle control FSM for the RV32I core, successor to the single-cycle combinational decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states and drives the shared-ALU/shared-memory datapath. It tolerates variable-latency memory through a `mem_ready` handshake with a timeout. It sits between the instruction register (IR) and the datapath muxes and enables.

## Interface
Parameters:
- `N`, 32, instruction width; only `Instruction[6:0]` is decoded.
- `TIMEOUT`, 15, maximum number of cycles to wait for `mem_ready` before faulting; must be ≥1.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `Instruction`  in  N  current IR contents; sampled only in DECODE.
- `mem_ready`  in  1  memory completes the access this cycle.
- `pc_write`, `pc_write_cond`, `ir_write`  out  1 each  PC/IR enables; `pc_write_cond` is ANDed with ALU zero in the datapath.
- `mem_read`, `mem_write`, `i_or_d`  out  1 each  memory strobes; `i_or_d` selects the address (0 = PC, 1 = ALUOut).
- `reg_write`  out  1  register file write enable.
- `wb_sel`  out  2  writeback source: 00 ALU result, 01 memory data, 10 PC (already +4).
- `alu_src_a`  out  2  ALU A source: 00 PC, 01 rs1, 10 old PC, 11 zero.
- `alu_src_b`  out  2  ALU B source: 00 rs2, 01 constant 4, 10 immediate.
- `alu_op`  out  2  00 add, 01 branch compare, 10 funct-decoded.
- `pc_src`  out  1  next-PC source: 0 ALU result, 1 ALUOut.
- `illegal`  out  1  one-cycle pulse on an unknown opcode.
- `mem_fault`  out  1  sticky; set on a memory timeout.
- `halted`  out  1  sticky; FSM is in HALT.

## Operation
- Moore FSM. Outputs are decoded from state only, except `ir_write` and `pc_write` in FETCH, which are qualified by `mem_ready`.
- Any output not listed for a state is 0.
- Reset: while `rst`=0, every output is 0. On the clock edge with `rst`=0, the state becomes FETCH, the wait counter clears, and `mem_fault` clears.

States and actions:
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=00, `alu_src_b`=01, `alu_op`=00.
  - On `mem_ready`: `ir_write`=1, `pc_write`=1, `pc_src`=0, then go to DECODE.
- DECODE: `alu_src_a`=10, `alu_src_b`=10 (branch target into ALUOut). Dispatch on opcode:
  - 0110011 or 0010011 → EXEC_ALU
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 or 0010111 → UPPER
  - 1110011 → HALT
  - any other opcode: `illegal`=1, go to FETCH.
- EXEC_ALU: `alu_src_a`=01, `alu_op`=10. `alu_src_b`=00 for R-type, 10 for I-type. Next: ALU_WB.
- ALU_WB: `reg_write`=1, `wb_sel`=00. Next: FETCH.
- MEM_ADDR: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00. Next: LOAD_MEM for a load, STORE_MEM for a store.
- LOAD_MEM: `mem_read`=1, `i_or_d`=1. On `mem_ready`, go to LOAD_WB.
- LOAD_WB: `reg_write`=1, `wb_sel`=01. Next: FETCH.
- STORE_MEM: `mem_write`=1, `i_or_d`=1. On `mem_ready`, go to FETCH.
- BRANCH: `alu_src_a`=01, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_src`=1. Next: FETCH.
- JAL: `reg_write`=1, `wb_sel`=10, `pc_write`=1, `pc_src`=1. Next: FETCH.
- JALR: `alu_src_a`=01, `alu_src_b`=10, `pc_write`=1, `pc_src`=0, `reg_write`=1, `wb_sel`=10. Next: FETCH.
- UPPER: `alu_src_b`=10, `reg_write`=1, `wb_sel`=00. `alu_src_a`=11 for LUI, 10 for AUIPC. Next: FETCH.
- HALT: `halted`=1. Remains in HALT until reset.

## Timing
- Wait counter: width $clog2(TIMEOUT+1). Cleared on entry to FETCH, LOAD_MEM and STORE_MEM; increments each cycle the FSM waits without `mem_ready`.
- Timeout: if the counter reaches TIMEOUT with `mem_ready`=0, then on the next edge `mem_fault` is set and the state becomes HALT.
- `mem_ready` in the same cycle as the timeout: the ready wins and the access completes normally.
- Latency with `mem_ready` asserted immediately:
  - R-type / I-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch, JAL, JALR, LUI, AUIPC: 3 cycles.
  - Each cycle of memory wait adds 1 cycle.
- `mem_ready` is ignored in every state that is not a memory state.
- Reset asserted mid-instruction aborts it. No `reg_write` or `mem_write` is issued in the reset cycle.
- `Instruction` changing outside DECODE has no effect.

## Structure
- `defines.v` holds the shared constants:
  - opcode macros (adding the I-arith, JAL, JALR, LUI, AUIPC and SYSTEM opcodes);
  - state encodings, 4 bits;
  - encodings for `wb_sel`, `alu_src_a`, `alu_src_b` and `alu_op`.
- One combinational sub-module, `mc_dispatch`: opcode in, DECODE next-state and `illegal` out. All other logic lives in `multicycle_control_unit`.

## Test plan
- ADD (0x00208033), `mem_ready` tied high → `ir_write` in cycle 1, then DECODE, EXEC_ALU, ALU_WB with `reg_write`=1 and `wb_sel`=00; back in FETCH at cycle 5.
- LW (opcode 0000011), `mem_ready` held low for 3 cycles in LOAD_MEM → `mem_read`=1 with `i_or_d`=1 for 4 cycles, then LOAD_WB with `wb_sel`=01; total 8 cycles.
- BEQ (opcode 1100011) → BRANCH asserts `pc_write_cond`=1, `pc_src`=1, `alu_op`=01, with `reg_write`=0 and `mem_write`=0 throughout.
- Opcode 1111111 → `illegal` pulses for one cycle in DECODE and the next state is FETCH. ECALL (opcode 1110011) → `halted` stays at 1 until `rst` is driven low.
- `mem_ready` held low in FETCH with TIMEOUT=15 → after 15 waiting cycles, `mem_fault`=1 and HALT. Drive `rst` low in the middle of STORE_MEM → `mem_write` drops to 0 that cycle, then restart from FETCH with all flags cleared.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit_pkg
// Description : Shared constants for the multi-cycle RV32I control unit:
//               opcodes, FSM state encoding and datapath mux encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_control_unit_pkg;

  // Major opcodes (Instruction[6:0])
  localparam logic [6:0] c_OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] c_OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

  // Controller states
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_ALU  = 4'd2,
    S_ALU_WB    = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_LOAD_MEM  = 4'd5,
    S_LOAD_WB   = 4'd6,
    S_STORE_MEM = 4'd7,
    S_BRANCH    = 4'd8,
    S_JAL       = 4'd9,
    S_JALR      = 4'd10,
    S_UPPER     = 4'd11,
    S_HALT      = 4'd12
  } state_t;

  // Writeback source
  localparam logic [1:0] c_WB_ALU = 2'b00;
  localparam logic [1:0] c_WB_MEM = 2'b01;
  localparam logic [1:0] c_WB_PC  = 2'b10;

  // ALU A source
  localparam logic [1:0] c_A_PC     = 2'b00;
  localparam logic [1:0] c_A_RS1    = 2'b01;
  localparam logic [1:0] c_A_OLD_PC = 2'b10;
  localparam logic [1:0] c_A_ZERO   = 2'b11;

  // ALU B source
  localparam logic [1:0] c_B_RS2  = 2'b00;
  localparam logic [1:0] c_B_FOUR = 2'b01;
  localparam logic [1:0] c_B_IMM  = 2'b10;

  // ALU operation class
  localparam logic [1:0] c_ALU_ADD   = 2'b00;
  localparam logic [1:0] c_ALU_BR    = 2'b01;
  localparam logic [1:0] c_ALU_FUNCT = 2'b10;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_unit_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : mc_dispatch
// Description : DECODE-state dispatch table: maps the opcode to the next
//               controller state and flags unknown opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_dispatch
  import multicycle_control_unit_pkg::*;
(
  input  logic [6:0] i_opcode,
  output state_t     o_next,
  output logic       o_illegal
);

  // Opcode lookup; unknown opcodes return to FETCH with the illegal flag
  always_comb begin
    o_next    = S_FETCH;
    o_illegal = 1'b0;
    case (i_opcode)
      c_OP_ALU_R, c_OP_ALU_I:  o_next = S_EXEC_ALU;
      c_OP_LOAD,  c_OP_STORE:  o_next = S_MEM_ADDR;
      c_OP_BRANCH:             o_next = S_BRANCH;
      c_OP_JAL:                o_next = S_JAL;
      c_OP_JALR:               o_next = S_JALR;
      c_OP_LUI,   c_OP_AUIPC:  o_next = S_UPPER;
      c_OP_SYSTEM:             o_next = S_HALT;
      default:                 o_illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : Moore control FSM for the multi-cycle RV32I datapath with a
//               mem_ready handshake and wait timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int N       = 32,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] Instruction,
  input  logic         mem_ready,
  output logic         pc_write,
  output logic         pc_write_cond,
  output logic         ir_write,
  output logic         mem_read,
  output logic         mem_write,
  output logic         i_or_d,
  output logic         reg_write,
  output logic [1:0]   wb_sel,
  output logic [1:0]   alu_src_a,
  output logic [1:0]   alu_src_b,
  output logic [1:0]   alu_op,
  output logic         pc_src,
  output logic         illegal,
  output logic         mem_fault,
  output logic         halted
);

  localparam int           W     = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] c_TMO = W'(TIMEOUT);
  localparam logic [W-1:0] c_ONE = W'(1);

  state_t       r_state;
  state_t       w_state_next;
  state_t       w_decode_next;
  logic [W-1:0] r_wait;
  logic [W-1:0] w_wait_next;
  logic         r_mem_fault;
  logic         w_fault_set;
  logic         w_illegal;
  // Opcode bit 5 separates R/I, store/load and LUI/AUIPC within a class;
  // it is captured in DECODE so later states ignore IR changes.
  logic         r_op5;
  logic         w_unused_instr;

  assign w_unused_instr = ^Instruction[N-1:7];

  mc_dispatch u_dispatch (
    .i_opcode  (Instruction[6:0]),
    .o_next    (w_decode_next),
    .o_illegal (w_illegal)
  );

  // State, wait counter, sticky fault and class bit registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_FETCH;
      r_wait      <= '0;
      r_mem_fault <= 1'b0;
      r_op5       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_wait_next;
      if (w_fault_set)
        r_mem_fault <= 1'b1;
      if (r_state == S_DECODE)
        r_op5 <= Instruction[5];
    end
  end

  assign mem_fault = rst & r_mem_fault;

  // Next-state and Moore output decode; everything is held at 0 in reset
  always_comb begin
    w_state_next  = r_state;
    w_wait_next   = r_wait;
    w_fault_set   = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = c_WB_ALU;
    alu_src_a     = c_A_PC;
    alu_src_b     = c_B_RS2;
    alu_op        = c_ALU_ADD;
    pc_src        = 1'b0;
    illegal       = 1'b0;
    halted        = 1'b0;
    if (rst) begin
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_a = c_A_PC;
          alu_src_b = c_B_FOUR;
          alu_op    = c_ALU_ADD;
          if (mem_ready) begin
            ir_write     = 1'b1;
            pc_write     = 1'b1;
            w_state_next = S_DECODE;
          end else if (r_wait == c_TMO) begin
            w_fault_set  = 1'b1;
            w_state_next = S_HALT;
          end else begin
            w_wait_next = r_wait + c_ONE;
          end
        end
        S_DECODE: begin
          alu_src_a    = c_A_OLD_PC;
          alu_src_b    = c_B_IMM;
          illegal      = w_illegal;
          w_state_next = w_decode_next;
        end
        S_EXEC_ALU: begin
          alu_src_a    = c_A_RS1;
          alu_op       = c_ALU_FUNCT;
          alu_src_b    = r_op5 ? c_B_RS2 : c_B_IMM;
          w_state_next = S_ALU_WB;
        end
        S_ALU_WB: begin
          reg_write    = 1'b1;
          wb_sel       = c_WB_ALU;
          w_state_next = S_FETCH;
        end
        S_MEM_ADDR: begin
          alu_src_a    = c_A_RS1;
          alu_src_b    = c_B_IMM;
          alu_op       = c_ALU_ADD;
          w_state_next = r_op5 ? S_STORE_MEM : S_LOAD_MEM;
        end
        S_LOAD_MEM: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          if (mem_ready) begin
            w_state_next = S_LOAD_WB;
          end else if (r_wait == c_TMO) begin
            w_fault_set  = 1'b1;
            w_state_next = S_HALT;
          end else begin
            w_wait_next = r_wait + c_ONE;
          end
        end
        S_LOAD_WB: begin
          reg_write    = 1'b1;
          wb_sel       = c_WB_MEM;
          w_state_next = S_FETCH;
        end
        S_STORE_MEM: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          if (mem_ready) begin
            w_state_next = S_FETCH;
          end else if (r_wait == c_TMO) begin
            w_fault_set  = 1'b1;
            w_state_next = S_HALT;
          end else begin
            w_wait_next = r_wait + c_ONE;
          end
        end
        S_BRANCH: begin
          alu_src_a     = c_A_RS1;
          alu_src_b     = c_B_RS2;
          alu_op        = c_ALU_BR;
          pc_write_cond = 1'b1;
          pc_src        = 1'b1;
          w_state_next  = S_FETCH;
        end
        S_JAL: begin
          reg_write    = 1'b1;
          wb_sel       = c_WB_PC;
          pc_write     = 1'b1;
          pc_src       = 1'b1;
          w_state_next = S_FETCH;
        end
        S_JALR: begin
          alu_src_a    = c_A_RS1;
          alu_src_b    = c_B_IMM;
          pc_write     = 1'b1;
          reg_write    = 1'b1;
          wb_sel       = c_WB_PC;
          w_state_next = S_FETCH;
        end
        S_UPPER: begin
          alu_src_a    = r_op5 ? c_A_ZERO : c_A_OLD_PC;
          alu_src_b    = c_B_IMM;
          reg_write    = 1'b1;
          wb_sel       = c_WB_ALU;
          w_state_next = S_FETCH;
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: w_state_next = S_FETCH;
      endcase
      // Every state change restarts the memory wait count
      if (w_state_next != r_state)
        w_wait_next = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_unit
// Description : Randomized scoreboard bench for multicycle_control_unit with
//               an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
  logic        reg_write, pc_src, illegal, mem_fault, halted;
  logic [1:0]  wb_sel, alu_src_a, alu_src_b, alu_op;

  always #5 clk = ~clk;

  multicycle_control_unit #(.N(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .Instruction(instr), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .illegal(illegal), .mem_fault(mem_fault), .halted(halted)
  );

  typedef struct packed {
    logic       pcw, pcwc, irw, mrd, mwr, iord, rw;
    logic [1:0] wb, sa, sb, op;
    logic       pcs, ill, mf, hlt;
  } ctl_t;

  typedef enum int {
    P_FETCH, P_DECODE, P_EXEC, P_ALU_WB, P_MEM_ADDR, P_LOAD_MEM, P_LOAD_WB,
    P_STORE_MEM, P_BRANCH, P_JAL, P_JALR, P_UPPER, P_HALT
  } phase_e;

  ctl_t  act;
  ctl_t  q_exp[$];
  string q_tag[$];
  ctl_t  mon_e;
  string mon_t;
  int    n_checks = 0;
  int    n_pass   = 0;

  // Reference-model state
  bit    mf;          // sticky memory-fault flag
  bit    aborted;     // current instruction killed by reset
  int    step_no;     // cycle index within current instruction
  int    rst_at;      // step index at which to pulse reset (-1 = none)

  assign act = '{pcw:pc_write, pcwc:pc_write_cond, irw:ir_write, mrd:mem_read,
                 mwr:mem_write, iord:i_or_d, rw:reg_write, wb:wb_sel,
                 sa:alu_src_a, sb:alu_src_b, op:alu_op, pcs:pc_src,
                 ill:illegal, mf:mem_fault, hlt:halted};

  // Expected control word for each phase of an instruction
  function automatic ctl_t phase_exp(phase_e ph, bit f);
    ctl_t e = '0;
    case (ph)
      P_FETCH:     begin e.mrd = 1; e.sb = 2'b01; e.irw = f; e.pcw = f; end
      P_DECODE:    begin e.sa = 2'b10; e.sb = 2'b10; e.ill = f; end
      P_EXEC:      begin e.sa = 2'b01; e.op = 2'b10; e.sb = f ? 2'b10 : 2'b00; end
      P_ALU_WB:    begin e.rw = 1; e.wb = 2'b00; end
      P_MEM_ADDR:  begin e.sa = 2'b01; e.sb = 2'b10; end
      P_LOAD_MEM:  begin e.mrd = 1; e.iord = 1; end
      P_LOAD_WB:   begin e.rw = 1; e.wb = 2'b01; end
      P_STORE_MEM: begin e.mwr = 1; e.iord = 1; end
      P_BRANCH:    begin e.sa = 2'b01; e.op = 2'b01; e.pcwc = 1; e.pcs = 1; end
      P_JAL:       begin e.rw = 1; e.wb = 2'b10; e.pcw = 1; e.pcs = 1; end
      P_JALR:      begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1; e.rw = 1; e.wb = 2'b10; end
      P_UPPER:     begin e.sb = 2'b10; e.rw = 1; e.sa = f ? 2'b11 : 2'b10; end
      P_HALT:      begin e.hlt = 1; e.mf = mf; end
      default:     e = '0;
    endcase
    return e;
  endfunction

  function automatic bit is_legal(logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};
  endfunction

  // Monitor: one DUT control word per cycle, compared away from the edge
  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      mon_e = q_exp.pop_front();
      mon_t = q_tag.pop_front();
      n_checks++;
      if (act === mon_e) n_pass++;
      else $display("FAIL %s t=%0t: got %b required %b", mon_t, $time, act, mon_e);
    end
  end

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      rst = 1'b0; mem_ready = 1'($urandom); instr = $urandom;
      q_exp.push_back('0); q_tag.push_back("reset");
      mf = 0;
      @(posedge clk); #1;
    end
  endtask

  // One instruction cycle, or a reset pulse if this is the abort point
  task automatic step(input ctl_t e, input bit rdy, input logic [31:0] iw, input string tag);
    if (step_no == rst_at) begin
      aborted = 1;
      reset_cycles(1);
    end else begin
      rst = 1'b1; mem_ready = rdy; instr = iw;
      q_exp.push_back(e); q_tag.push_back(tag);
      @(posedge clk); #1;
    end
    step_no++;
  endtask

  // Memory access phase: ready arrives after k wait cycles; beyond TMO it faults
  task automatic mem_phase(input phase_e ph, input int k, input string tag, output bit fault);
    bit r;
    fault = 0;
    for (int i = 0; i <= TMO; i++) begin
      r = (i >= k);
      step(phase_exp(ph, r), r, $urandom, tag);
      if (aborted || r) return;
    end
    fault = 1;
  endtask

  task automatic halt_tail(input bit fault);
    if (fault) mf = 1;
    for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
      step(phase_exp(P_HALT, 0), 1'($urandom), $urandom, "halt");
      if (aborted) return;
    end
    reset_cycles($urandom_range(1, 2));
  endtask

  task automatic run_instr(input logic [31:0] iw, input int kf, input int km, input int ra);
    logic [6:0] op;
    bit f;
    op = iw[6:0];
    aborted = 0; step_no = 0; rst_at = ra;
    mem_phase(P_FETCH, kf, "fetch", f);
    if (aborted) return;
    if (f) begin halt_tail(1); return; end
    step(phase_exp(P_DECODE, !is_legal(op)), 1'($urandom), iw, "decode");
    if (aborted || !is_legal(op)) return;
    case (op)
      7'b0110011, 7'b0010011: begin
        step(phase_exp(P_EXEC, op == 7'b0010011), 1'($urandom), $urandom, "exec");
        if (aborted) return;
        step(phase_exp(P_ALU_WB, 0), 1'($urandom), $urandom, "alu_wb");
      end
      7'b0000011: begin
        step(phase_exp(P_MEM_ADDR, 0), 1'($urandom), $urandom, "ld_addr");
        if (aborted) return;
        mem_phase(P_LOAD_MEM, km, "ld_mem", f);
        if (aborted) return;
        if (f) begin halt_tail(1); return; end
        step(phase_exp(P_LOAD_WB, 0), 1'($urandom), $urandom, "ld_wb");
      end
      7'b0100011: begin
        step(phase_exp(P_MEM_ADDR, 0), 1'($urandom), $urandom, "st_addr");
        if (aborted) return;
        mem_phase(P_STORE_MEM, km, "st_mem", f);
        if (aborted) return;
        if (f) halt_tail(1);
      end
      7'b1100011: step(phase_exp(P_BRANCH, 0), 1'($urandom), $urandom, "branch");
      7'b1101111: step(phase_exp(P_JAL, 0),    1'($urandom), $urandom, "jal");
      7'b1100111: step(phase_exp(P_JALR, 0),   1'($urandom), $urandom, "jalr");
      7'b0110111: step(phase_exp(P_UPPER, 1),  1'($urandom), $urandom, "lui");
      7'b0010111: step(phase_exp(P_UPPER, 0),  1'($urandom), $urandom, "auipc");
      default:    halt_tail(0);   // SYSTEM
    endcase
  endtask

  function automatic int rand_wait();
    int r = $urandom_range(0, 99);
    if (r < 3)  return TMO + 1;
    if (r < 6)  return TMO;
    if (r < 50) return 0;
    return $urandom_range(1, 4);
  endfunction

  logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                7'b0010111};

  initial begin
    logic [31:0] w;
    logic [6:0]  op;
    int          r;
    rst = 1'b0; mem_ready = 1'b0; instr = '0; mf = 0;
    @(posedge clk); #1;
    reset_cycles(3);

    // Directed cases
    run_instr(32'h00208033, 0, 0, -1);            // ADD, immediate ready
    run_instr(32'h00012083, 0, 3, -1);            // LW with 3 wait cycles
    run_instr(32'h00208063, 0, 0, -1);            // BEQ
    run_instr(32'h0000007F, 0, 0, -1);            // illegal opcode
    run_instr(32'h00000073, 0, 0, -1);            // ECALL -> HALT
    run_instr(32'h00208033, TMO + 1, 0, -1);      // fetch timeout -> fault
    run_instr(32'h00208033, TMO, 0, -1);          // ready on the timeout cycle
    run_instr(32'h00112023, 0, 10, 5);            // reset mid STORE_MEM
    run_instr(32'h00500093, 0, 0, -1);            // ADDI after the abort
    run_instr(32'h00112023, 0, TMO + 1, -1);      // store timeout -> fault

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      w = $urandom;
      r = $urandom_range(0, 99);
      if (r < 4) op = 7'b1110011;
      else if (r < 10) begin
        op = 7'($urandom);
        while (is_legal(op)) op = 7'($urandom);
      end else op = legal_ops[$urandom_range(0, 8)];
      run_instr({w[31:7], op}, rand_wait(), rand_wait(),
                ($urandom_range(0, 39) < 2) ? int'($urandom_range(0, 6)) : -1);
    end

    n_checks++;
    if (q_exp.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expected words left, required 0", q_exp.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
